servo_pulse_decoder: RTL and testbench

Receive-side counterpart of the servo PWM generator: measures the high time of an incoming servo-style PWM pulse train and decodes it back into a direction bit. It samples `pwm_in` from the motor-drive path (loopback or external servo tester), with nominal widths of 100000 cycles (CCW) and 200000 cycles (CW) in a 2000000-cycle frame. It reports the measured width with a one-cycle valid strobe, flags out-of-band pulses, and drops `active` when the pulse train is lost.

---
 rtl/motor_pkg.sv | 23 ++
 rtl/pwm_edge_sync.sv | 67 ++++++
 rtl/servo_pulse_decoder.sv | 137 +++++++++++++
 tb/tb_servo_pulse_decoder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared motor-path types and defaults: servo decoder FSM states, nominal
// PWM widths and the 21-bit pulse-width type used by generator and decoder.
package motor_pkg;

  localparam int unsigned FRAME_CYCLES  = 2000000;
  localparam int unsigned CCW_WIDTH_DEF = 100000;
  localparam int unsigned CW_WIDTH_DEF  = 200000;
  localparam int unsigned PWM_WIDTH_W   = 21;

  typedef logic [PWM_WIDTH_W-1:0] pwm_width_t;

  typedef enum logic [1:0] {
    WAIT_LOW,
    WAIT_RISE,
    MEASURE
  } servo_dec_state_t;

  function automatic logic in_band(input pwm_width_t w, input pwm_width_t lo,
                                   input pwm_width_t hi);
    return (w >= lo) && (w <= hi);
  endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer for pwm_in with registered level/rise/fall outputs.
// Optional 4-cycle stability filter when SERVO_DEC_GLITCH_FILTER_EN is defined.
module pwm_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic pwm_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic sync1_reg, sync2_reg, filt_level;
  logic s_d_reg, rise_reg, fall_reg;

  // The pipe resets to "high" so a pulse already present at reset release
  // never produces a rise, and a low input only yields an ignored fall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= pwm_in;
      sync2_reg <= sync1_reg;
    end
  end

`ifdef SERVO_DEC_GLITCH_FILTER_EN
  logic       filt_reg;
  logic [1:0] stable_cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_reg       <= 1'b1;
      stable_cnt_reg <= 2'd0;
    end else if (sync2_reg == filt_reg) begin
      stable_cnt_reg <= 2'd0;
    end else if (stable_cnt_reg == 2'd3) begin
      filt_reg       <= sync2_reg;
      stable_cnt_reg <= 2'd0;
    end else begin
      stable_cnt_reg <= stable_cnt_reg + 2'd1;
    end
  end

  assign filt_level = filt_reg;
`else
  assign filt_level = sync2_reg;
`endif

  // Level, rise and fall are registered together so they stay cycle-aligned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_d_reg  <= 1'b1;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      s_d_reg  <= filt_level;
      rise_reg <= filt_level & ~s_d_reg;
      fall_reg <= ~filt_level & s_d_reg;
    end
  end

  assign s    = s_d_reg;
  assign rise = rise_reg;
  assign fall = fall_reg;

endmodule

// File: rtl/servo_pulse_decoder.sv
// Measures servo PWM high time, decodes direction, flags out-of-band pulses
// and loss of signal. SERVO_DEC_GLITCH_FILTER_EN enables the input filter.
module servo_pulse_decoder
  import motor_pkg::*;
#(
  parameter int unsigned CCW_WIDTH = CCW_WIDTH_DEF,
  parameter int unsigned CW_WIDTH  = CW_WIDTH_DEF,
  parameter int unsigned TOL       = 10000,
  parameter int unsigned TIMEOUT   = FRAME_CYCLES + FRAME_CYCLES / 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pwm_in,
  output logic        direction,
  output logic [20:0] pulse_width,
  output logic        valid,
  output logic        error,
  output logic        active
);

  localparam pwm_width_t CCW_LO    = pwm_width_t'(CCW_WIDTH - TOL);
  localparam pwm_width_t CCW_HI    = pwm_width_t'(CCW_WIDTH + TOL);
  localparam pwm_width_t CW_LO     = pwm_width_t'(CW_WIDTH - TOL);
  localparam pwm_width_t CW_HI     = pwm_width_t'(CW_WIDTH + TOL);
  localparam logic [21:0] TIMEOUT_T = 22'(TIMEOUT);

  logic s, rise, fall;

  servo_dec_state_t state_reg, state_next;
  pwm_width_t       count_reg, count_next;
  pwm_width_t       width_reg, width_next;
  logic [21:0]      timer_reg, timer_next;
  logic             direction_reg, direction_next;
  logic             valid_reg, valid_next;
  logic             error_reg, error_next;
  logic             active_reg, active_next;
  logic             timeout_hit;

  pwm_edge_sync u_edge_sync (
    .clk   (clk),
    .reset (reset),
    .pwm_in(pwm_in),
    .s     (s),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= WAIT_LOW;
      count_reg     <= '0;
      width_reg     <= '0;
      timer_reg     <= '0;
      direction_reg <= 1'b0;
      valid_reg     <= 1'b0;
      error_reg     <= 1'b0;
      active_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      width_reg     <= width_next;
      timer_reg     <= timer_next;
      direction_reg <= direction_next;
      valid_reg     <= valid_next;
      error_reg     <= error_next;
      active_reg    <= active_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    width_next     = width_reg;
    direction_next = direction_reg;
    valid_next     = 1'b0;
    error_next     = 1'b0;
    active_next    = active_reg;

    // Timeout is a single event on entry into saturation, not a level.
    timeout_hit = !rise && (timer_reg == TIMEOUT_T - 22'd1);
    if (rise)
      timer_next = '0;
    else if (timer_reg == TIMEOUT_T)
      timer_next = timer_reg;
    else
      timer_next = timer_reg + 22'd1;

    case (state_reg)
      WAIT_LOW: begin
        if (!s) state_next = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (rise) begin
          state_next = MEASURE;
          count_next = pwm_width_t'(1);
        end
      end
      MEASURE: begin
        if (fall) begin
          state_next = WAIT_RISE;
          width_next = count_reg;
          if (in_band(count_reg, CCW_LO, CCW_HI)) begin
            direction_next = 1'b0;
            valid_next     = 1'b1;
          end else if (in_band(count_reg, CW_LO, CW_HI)) begin
            direction_next = 1'b1;
            valid_next     = 1'b1;
          end else begin
            error_next = 1'b1;
          end
        end else if (s && (count_reg != '1)) begin
          count_next = count_reg + 1'b1;
        end
      end
      default: state_next = WAIT_LOW;
    endcase

    if (valid_next) active_next = 1'b1;

    // Loss of signal overrides any pulse completing in the same cycle.
    if (timeout_hit) begin
      state_next     = WAIT_LOW;
      width_next     = width_reg;
      direction_next = direction_reg;
      valid_next     = 1'b0;
      error_next     = (state_reg == MEASURE);
      active_next    = 1'b0;
    end
  end

  assign direction   = direction_reg;
  assign pulse_width = width_reg;
  assign valid       = valid_reg;
  assign error       = error_reg;
  assign active      = active_reg;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Scoreboard bench for servo_pulse_decoder with scaled-down widths/timeout;
// a band-classification model queues expected strobes, a monitor checks them.
module tb_servo_pulse_decoder;

  localparam int unsigned CCW = 100;
  localparam int unsigned CW  = 200;
  localparam int unsigned TOL = 10;
  localparam int unsigned TO  = 300;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pwm_in = 1'b0;
  logic        direction, valid, error, active;
  logic [20:0] pulse_width;

  always #5 clk = ~clk;

  servo_pulse_decoder #(
    .CCW_WIDTH(CCW),
    .CW_WIDTH (CW),
    .TOL      (TOL),
    .TIMEOUT  (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pwm_in     (pwm_in),
    .direction  (direction),
    .pulse_width(pulse_width),
    .valid      (valid),
    .error      (error),
    .active     (active)
  );

  typedef struct {
    bit is_err;
    int width;
    bit dir;
    bit active_exp;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  last_valid_cyc = 0;
  bit  model_dir = 1'b0;
  int  model_width = 0;
  bit  model_active = 1'b0;
  int  band_edges[8] = '{89, 90, 110, 111, 189, 190, 210, 211};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: classify a pulse width into the inclusive direction bands.
  task automatic expect_pulse(input int w);
    ev_t e;
`ifdef SERVO_DEC_GLITCH_FILTER_EN
    if (w < 4) return;
`endif
    if (w >= int'(CCW - TOL) && w <= int'(CCW + TOL)) begin
      model_dir = 1'b0; model_active = 1'b1; e.is_err = 1'b0;
    end else if (w >= int'(CW - TOL) && w <= int'(CW + TOL)) begin
      model_dir = 1'b1; model_active = 1'b1; e.is_err = 1'b0;
    end else begin
      e.is_err = 1'b1;
    end
    model_width  = w;
    e.width      = w;
    e.dir        = model_dir;
    e.active_exp = model_active;
    exp_q.push_back(e);
  endtask

  task automatic expect_stuck();
    ev_t e;
    model_active = 1'b0;
    e.is_err = 1'b1; e.width = model_width; e.dir = model_dir; e.active_exp = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic send_pulse(input int hi, input int lo);
    pwm_in = 1'b1;
    repeat (hi) @(negedge clk);
    pwm_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  // Monitor: every strobe pops one expected event.
  initial begin
    bit  prev_strobe;
    ev_t e;
    int  diff;
    prev_strobe = 1'b0;
    forever begin
      @(negedge clk);
      if (valid || error) begin
        $display("[TB] cyc=%0d valid=%0b error=%0b width=%0d dir=%0b active=%0b",
                 cyc, valid, error, pulse_width, direction, active);
        check("no_dual_strobe", int'(valid && error), 0);
        check("no_back_to_back", int'(prev_strobe), 0);
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_strobe: got valid=%0b error=%0b width=%0d, expected no strobe",
                   valid, error, pulse_width);
        end else begin
          e = exp_q.pop_front();
          check("strobe_kind_error", int'(error), int'(e.is_err));
          diff = int'(pulse_width) - e.width;
          tests++;
          if (diff > 1 || diff < -1) begin
            fails++;
            $display("FAIL pulse_width: got %0d, expected %0d +-1", pulse_width, e.width);
          end
          check("direction", int'(direction), int'(e.dir));
          check("active", int'(active), int'(e.active_exp));
        end
        if (valid) last_valid_cyc = cyc;
      end
      prev_strobe = valid || error;
    end
  end

  initial begin
    int w, lo, r, n;
    bit seen;

    // Pulse held high across reset release.
    @(negedge clk);
    reset = 1'b0; pwm_in = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_direction", int'(direction), 0);
    check("rst_pulse_width", int'(pulse_width), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_error", int'(error), 0);
    check("rst_active", int'(active), 0);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    pwm_in = 1'b0;
    repeat (20) @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      expect_pulse(CCW); send_pulse(CCW, 150);
    end
    expect_pulse(CW);  send_pulse(CW, 60);
    expect_pulse(90);  send_pulse(90, 150);
    expect_pulse(210); send_pulse(210, 60);
    expect_pulse(150); send_pulse(150, 100);
    expect_pulse(2);   send_pulse(2, 20);
    expect_pulse(CCW); send_pulse(CCW, 100);

    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 3);
      case (r)
        0: w = $urandom_range(CCW - TOL, CCW + TOL);
        1: w = $urandom_range(CW - TOL, CW + TOL);
        2: w = $urandom_range(5, 260);
        default: w = band_edges[$urandom_range(0, 7)];
      endcase
      lo = $urandom_range(5, 285 - w);
      expect_pulse(w); send_pulse(w, lo);
    end

    // Loss of signal with input low: active drops TO cycles after the rise.
    expect_pulse(CCW); send_pulse(CCW, 0);
    seen = 1'b0; n = 0;
    while (!seen && n < 1000) begin
      @(negedge clk);
      n++;
      if (!active) seen = 1'b1;
    end
    check("timeout_active_fell", int'(seen), 1);
    check("timeout_latency", cyc - last_valid_cyc, int'(TO - CCW));
    model_active = 1'b0;
    repeat (10) @(negedge clk);

    // Stuck high: one error, active cleared, width held.
    expect_pulse(CW); send_pulse(CW, 50);
    expect_stuck();
    send_pulse(400, 20);
    check("stuck_active", int'(active), 0);

    // Reset mid-pulse clears outputs immediately.
    expect_pulse(CW); send_pulse(CW, 50);
    pwm_in = 1'b1;
    repeat (50) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_direction", int'(direction), 0);
    check("midrst_pulse_width", int'(pulse_width), 0);
    check("midrst_valid", int'(valid), 0);
    check("midrst_error", int'(error), 0);
    check("midrst_active", int'(active), 0);
    model_dir = 1'b0; model_width = 0; model_active = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (60) @(negedge clk);
    pwm_in = 1'b0;
    repeat (20) @(negedge clk);
    expect_pulse(CCW); send_pulse(CCW, 100);

    repeat (20) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
